// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like slave port between the inst and data masters
//   and routes each completion back to the master that issued it, in request order.
//   Optional macro ARB_ROUND_ROBIN_EN: round-robin idle selection instead of data>inst.
//   Ports: aclk/areset (async, active-high); inst_* and data_* master sides
//   (req/wr/size|strb/addr/wdata in, rdata/addr_ok/data_ok out); m_* slave side;
//   outstanding = occupancy of the in-order id FIFO.
module sram_like_arbiter #(
  parameter int MAX_OUT = 4,
  parameter int PTR_W   = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic [31:0]      inst_rdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [3:0]       data_strb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic [31:0]      data_rdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [3:0]       m_strb,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  output logic [PTR_W:0]   outstanding
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t             r_state, w_next;
  logic               r_lock_id;
  logic [MAX_OUT-1:0] r_fifo;
  logic [PTR_W:0]     r_wr_ptr, r_rd_ptr;
  logic               w_idle_id, w_sel_vld, w_sel_id, w_full, w_accept, w_pop, w_head;
`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr;
  // r_rr names the master that wins a tie; a lone requester always wins
  assign w_idle_id = (inst_req & data_req) ? r_rr : data_req;
`else
  assign w_idle_id = data_req;
`endif
  assign w_sel_vld    = (r_state == HOLD) | inst_req | data_req;
  assign w_sel_id     = (r_state == HOLD) ? r_lock_id : w_idle_id;
  assign outstanding  = r_wr_ptr - r_rd_ptr;
  assign w_full       = outstanding == (PTR_W+1)'(MAX_OUT);
  assign m_req        = w_sel_vld & (w_sel_id ? data_req : inst_req) & ~w_full;
  assign m_wr         = w_sel_vld & (w_sel_id ? data_wr : inst_wr);
  assign m_size       = ~w_sel_vld ? 2'b00 : w_sel_id ? 2'b10 : inst_size;
  assign m_strb       = ~w_sel_vld ? 4'h0 : w_sel_id ? data_strb : 4'hf;
  assign m_addr       = ~w_sel_vld ? 32'h0 : w_sel_id ? data_addr : inst_addr;
  assign m_wdata      = ~w_sel_vld ? 32'h0 : w_sel_id ? data_wdata : inst_wdata;
  assign w_accept     = m_req & m_addr_ok;
  // a data_ok with nothing outstanding is a protocol error and is dropped
  assign w_pop        = m_data_ok & (outstanding != '0);
  assign w_head       = r_fifo[r_rd_ptr[PTR_W-1:0]];
  assign inst_addr_ok = w_accept & ~w_sel_id;
  assign data_addr_ok = w_accept & w_sel_id;
  assign inst_data_ok = w_pop & ~w_head;
  assign data_data_ok = w_pop & w_head;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? ((m_req & ~m_addr_ok) ? HOLD : IDLE) : (w_accept ? IDLE : HOLD);
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_lock_id <= 1'b0;
      r_fifo    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr      <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_lock_id <= (r_state == IDLE) ? w_sel_id : r_lock_id;
      if (w_accept) r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_sel_id;
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      if (w_accept) r_rr <= ~w_sel_id;
`endif
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scoreboard bench for sram_like_arbiter
module tb_sram_like_arbiter;
  logic        aclk = 1'b0, areset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_strb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [3:0]  m_strb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  outstanding;
  int total = 0, bad = 0;
  typedef struct {bit dok; bit id; logic [31:0] d;} exp_t;
  exp_t q[$];
  sram_like_arbiter dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_strb(data_strb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_strb(m_strb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .outstanding(outstanding)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic ex(input bit dok, input bit id, input logic [31:0] d);
    exp_t e;
    e.dok = dok; e.id = id; e.d = d;
    q.push_back(e);
  endtask
  task automatic mon(input bit dok, input bit id, input logic [31:0] d);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected dok=%0d id=%0d got=%h exp=none", dok, id, d);
    end else begin
      e = q.pop_front();
      if (e.dok != dok || e.id != id || (dok && e.d !== d)) begin
        bad++;
        $display("FAIL event got dok=%0d id=%0d d=%h exp dok=%0d id=%0d d=%h", dok, id, d, e.dok, e.id, e.d);
      end
    end
  endtask
  always @(negedge aclk) begin
    if (inst_addr_ok) mon(0, 0, 32'h0);
    if (data_addr_ok) mon(0, 1, 32'h0);
    if (inst_data_ok) mon(1, 0, inst_rdata);
    if (data_data_ok) mon(1, 1, data_rdata);
  end
  task automatic clr();
    inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_strb = 0; data_addr = 0; data_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
  endtask
  task automatic step();
    @(posedge aclk); #1;
  endtask
  task automatic hs_zero(input string n);
    chk(n, {28'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, m_req}, 32'h0);
  endtask
  task automatic do_reset();
    areset = 1; clr();
    #2;
    chk("rst_outstanding", 32'(outstanding), 0);
    hs_zero("rst_handshakes");
    chk("rst_m_addr", m_addr, 0);
    step(); step();
    areset = 0;
  endtask
  task automatic dok(input logic [31:0] d);
    m_data_ok = 1; m_rdata = d;
    step();
    m_data_ok = 0;
  endtask
  bit exp_ids[3];
  initial begin
    do_reset();
    // 1: inst only
    inst_req = 1; inst_addr = 32'hBFC00000; m_addr_ok = 1; ex(0, 0, 0);
    #2;
    chk("t1_m_req", 32'(m_req), 1);
    chk("t1_m_addr", m_addr, 32'hBFC00000);
    chk("t1_m_strb", 32'(m_strb), 32'hf);
    step(); clr();
    chk("t1_out1", 32'(outstanding), 1);
    step();
    ex(1, 0, 32'h3C08BFAF); dok(32'h3C08BFAF);
    chk("t1_out0", 32'(outstanding), 0);
    // 2: both request, slave stalls 3 cycles
    inst_req = 1; inst_addr = 32'h1000; inst_size = 2'b01;
    data_req = 1; data_addr = 32'h2000; data_strb = 4'h3;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t2_hold_addr", m_addr, 32'h2000);
      chk("t2_hold_strb", 32'(m_strb), 32'h3);
      step();
    end
    m_addr_ok = 1; ex(0, 1, 0);
    step();
    data_req = 0; ex(0, 0, 0);
    #2;
    chk("t2_inst_addr", m_addr, 32'h1000);
    chk("t2_inst_size", 32'(m_size), 32'h1);
    chk("t2_inst_strb", 32'(m_strb), 32'hf);
    step(); clr();
    chk("t2_out2", 32'(outstanding), 2);
    ex(1, 1, 32'hAA); dok(32'hAA);
    ex(1, 0, 32'hBB); dok(32'hBB);
    // 3: fill FIFO, full blocks m_req even with a pop
    data_req = 1; data_addr = 32'h3000; data_strb = 4'hf; m_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin ex(0, 1, 0); step(); end
    m_addr_ok = 0;
    #2;
    chk("t3_full_out", 32'(outstanding), 4);
    chk("t3_full_req", 32'(m_req), 0);
    step();
    m_data_ok = 1; m_rdata = 32'h44; ex(1, 1, 32'h44);
    #2;
    chk("t3_pop_req", 32'(m_req), 0);
    step();
    m_data_ok = 0;
    #2;
    chk("t3_out3", 32'(outstanding), 3);
    chk("t3_req_back", 32'(m_req), 1);
    step();
    m_addr_ok = 1; ex(0, 1, 0);
    step(); clr();
    chk("t3_out4", 32'(outstanding), 4);
    for (int i = 1; i <= 4; i++) begin ex(1, 1, 32'(i)); dok(32'(i)); end
    // 4: interleaved order
    inst_req = 1; inst_addr = 32'h100; m_addr_ok = 1; ex(0, 0, 0); step();
    inst_req = 0; data_req = 1; data_addr = 32'h200; ex(0, 1, 0); step();
    data_req = 0; inst_req = 1; inst_addr = 32'h104; ex(0, 0, 0); step();
    clr();
    ex(1, 0, 32'h11); dok(32'h11);
    ex(1, 1, 32'h22); dok(32'h22);
    ex(1, 0, 32'h33); dok(32'h33);
    // 5: both request continuously
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_ids = '{0, 1, 0};
`else
    exp_ids = '{1, 1, 1};
`endif
    inst_req = 1; inst_addr = 32'h500; data_req = 1; data_addr = 32'h600; m_addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      ex(0, exp_ids[i], 0);
      #2;
      chk("t5_grant_addr", m_addr, exp_ids[i] ? 32'h600 : 32'h500);
      step();
    end
    clr();
    for (int i = 0; i < 3; i++) begin ex(1, exp_ids[i], 32'(i + 7)); dok(32'(i + 7)); end
    // 6: stray data_ok, then reset with entries in flight
    m_data_ok = 1; m_rdata = 32'hDEAD;
    #2;
    chk("t6_stray_dok", {30'h0, inst_data_ok, data_data_ok}, 0);
    step(); clr();
    chk("t6_stray_out", 32'(outstanding), 0);
    inst_req = 1; m_addr_ok = 1; ex(0, 0, 0); step();
    inst_req = 0; data_req = 1; ex(0, 1, 0); step();
    clr();
    chk("t6_out2", 32'(outstanding), 2);
    areset = 1; m_data_ok = 1; m_rdata = 32'h77;
    #2;
    chk("t6_rst_out", 32'(outstanding), 0);
    hs_zero("t6_rst_hs");
    step();
    areset = 0; clr();
    #2;
    chk("t6_post_out", 32'(outstanding), 0);
    hs_zero("t6_post_hs");
    step(); step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
